rob_retire_tracker: RTL and testbench

Completion-tracking and in-order retirement half of the reorder buffer. Allocates ROB indices to dispatched instructions, collects completion reports from the three functional units and the LoadStoreQueue, and retires up to two completed instructions per cycle in program order. Its retire outputs drive the LoadStoreQueue's `retire_ROB_index_1/2` inputs, closing the loop on the LSQ's `completed_ROB_index/completed_valid` report.

---
 rtl/rob_pkg.sv | 23 ++
 rtl/rob_done_bank.sv | 65 ++++++
 rtl/rob_retire_tracker.sv | 137 +++++++++++++
 tb/tb_rob_retire_tracker.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_pkg.sv
// Shared ROB definitions used by the retire tracker, the LoadStoreQueue and dispatch.
package rob_pkg;

  localparam int ROB_DEPTH = 64;
  localparam int ROB_IDX_W = 6;

  typedef logic [ROB_IDX_W-1:0] rob_idx_t;

  // Completion reporters, in the order they are packed onto the done bank.
  localparam int ROB_CPL_PORTS = 4;
  typedef enum logic [1:0] {
    CPL_FU1 = 2'd0,
    CPL_FU2 = 2'd1,
    CPL_FU3 = 2'd2,
    CPL_LSQ = 2'd3
  } cpl_port_e;

  // Number of entries named by a pair of in-order request/ready strobes.
  function automatic logic [1:0] pair_count(input logic first, input logic second);
    return first ? (second ? 2'd2 : 2'd1) : 2'd0;
  endfunction

endpackage

// File: rtl/rob_done_bank.sv
// Per-entry busy/done bit arrays for the reorder buffer. Completions only mark
// entries that are currently busy; retire clears and allocation sets override
// any completion arriving on the same edge.
module rob_done_bank
  import rob_pkg::*;
#(
  parameter int DEPTH = ROB_DEPTH,
  parameter int IDX_W = ROB_IDX_W
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [ROB_CPL_PORTS-1:0]             cpl_vld_i,
  input  logic [ROB_CPL_PORTS-1:0][IDX_W-1:0]  cpl_idx_i,
  input  logic [1:0]                           alloc_vld_i,
  input  logic [1:0][IDX_W-1:0]                alloc_idx_i,
  input  logic [1:0]                           ret_vld_i,
  input  logic [1:0][IDX_W-1:0]                rd_idx_i,
  output logic [1:0]                           rd_busy_o,
  output logic [1:0]                           rd_done_o
);

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [DEPTH-1:0] done_q, done_d;

  // Next-state for the bit arrays: completion, then retire clear, then allocate set.
  always_comb begin
    busy_d = busy_q;
    done_d = done_q;
    for (int p = 0; p < ROB_CPL_PORTS; p++) begin
      if (cpl_vld_i[p] && busy_q[cpl_idx_i[p]]) begin
        done_d[cpl_idx_i[p]] = 1'b1;
      end
    end
    // Retire clears the two read-port entries (head and head+1).
    for (int r = 0; r < 2; r++) begin
      if (ret_vld_i[r]) begin
        busy_d[rd_idx_i[r]] = 1'b0;
        done_d[rd_idx_i[r]] = 1'b0;
      end
    end
    for (int a = 0; a < 2; a++) begin
      if (alloc_vld_i[a]) begin
        busy_d[alloc_idx_i[a]] = 1'b1;
        done_d[alloc_idx_i[a]] = 1'b0;
      end
    end
  end

  // Bit-array state register; reset abandons every in-flight entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= '0;
      done_q <= '0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign rd_busy_o[0] = busy_q[rd_idx_i[0]];
  assign rd_busy_o[1] = busy_q[rd_idx_i[1]];
  assign rd_done_o[0] = done_q[rd_idx_i[0]];
  assign rd_done_o[1] = done_q[rd_idx_i[1]];

endmodule

// File: rtl/rob_retire_tracker.sv
// Reorder-buffer completion tracker: allocates indices at the tail, collects
// completions from three FUs and the LSQ, and retires up to two entries per
// cycle in program order from the head.
module rob_retire_tracker
  import rob_pkg::*;
#(
  parameter int DEPTH = ROB_DEPTH,
  parameter int IDX_W = ROB_IDX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alloc_req_1,
  input  logic             alloc_req_2,
  output logic             alloc_ready,
  output logic [IDX_W-1:0] alloc_ROB_index_1,
  output logic [IDX_W-1:0] alloc_ROB_index_2,
  input  logic             FU_1_valid,
  input  logic [IDX_W-1:0] FU_1_ROB_index,
  input  logic             FU_2_valid,
  input  logic [IDX_W-1:0] FU_2_ROB_index,
  input  logic             FU_3_valid,
  input  logic [IDX_W-1:0] FU_3_ROB_index,
  input  logic             completed_valid,
  input  logic [IDX_W-1:0] completed_ROB_index,
  output logic             retire_valid_1,
  output logic             retire_valid_2,
  output logic [IDX_W-1:0] retire_ROB_index_1,
  output logic [IDX_W-1:0] retire_ROB_index_2,
  output logic [IDX_W:0]   count,
  output logic             empty
);

  logic [IDX_W-1:0] head_q, head_d;
  logic [IDX_W-1:0] tail_q, tail_d;
  logic [IDX_W:0]   count_q, count_d;
  logic             rv1_q, rv1_d, rv2_q, rv2_d;
  logic [IDX_W-1:0] ri1_q, ri1_d, ri2_q, ri2_d;

  logic [IDX_W-1:0] head_p1;
  logic [IDX_W-1:0] tail_p1;
  logic [1:0]       n_alloc;
  logic [1:0]       n_ret;
  logic             r1, r2;

  logic [ROB_CPL_PORTS-1:0]            cpl_vld;
  logic [ROB_CPL_PORTS-1:0][IDX_W-1:0] cpl_idx;
  logic [1:0]                          bank_alloc_vld;
  logic [1:0][IDX_W-1:0]               bank_alloc_idx;
  logic [1:0][IDX_W-1:0]               bank_rd_idx;
  logic [1:0]                          bank_busy;
  logic [1:0]                          bank_done;

  // Pointer arithmetic wraps naturally because DEPTH == 2**IDX_W.
  assign head_p1 = head_q + IDX_W'(1);
  assign tail_p1 = tail_q + IDX_W'(1);

  // Readiness looks only at the registered count, never at same-cycle retires.
  assign alloc_ready       = (count_q <= (IDX_W+1)'(DEPTH-2));
  assign alloc_ROB_index_1 = tail_q;
  assign alloc_ROB_index_2 = tail_p1;
  assign n_alloc           = alloc_ready ? pair_count(alloc_req_1, alloc_req_2) : 2'd0;

  assign cpl_vld[CPL_FU1] = FU_1_valid;
  assign cpl_vld[CPL_FU2] = FU_2_valid;
  assign cpl_vld[CPL_FU3] = FU_3_valid;
  assign cpl_vld[CPL_LSQ] = completed_valid;
  assign cpl_idx[CPL_FU1] = FU_1_ROB_index;
  assign cpl_idx[CPL_FU2] = FU_2_ROB_index;
  assign cpl_idx[CPL_FU3] = FU_3_ROB_index;
  assign cpl_idx[CPL_LSQ] = completed_ROB_index;

  assign bank_alloc_vld[0] = (n_alloc != 2'd0);
  assign bank_alloc_vld[1] = (n_alloc == 2'd2);
  assign bank_alloc_idx[0] = tail_q;
  assign bank_alloc_idx[1] = tail_p1;
  assign bank_rd_idx[0]    = head_q;
  assign bank_rd_idx[1]    = head_p1;

  rob_done_bank #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_done_bank (
    .clk         (clk),
    .rst_n       (rst_n),
    .cpl_vld_i   (cpl_vld),
    .cpl_idx_i   (cpl_idx),
    .alloc_vld_i (bank_alloc_vld),
    .alloc_idx_i (bank_alloc_idx),
    .ret_vld_i   ({r2, r1}),
    .rd_idx_i    (bank_rd_idx),
    .rd_busy_o   (bank_busy),
    .rd_done_o   (bank_done)
  );

  // Retire decision from registered state, plus pointer/count next-state.
  always_comb begin
    r1      = bank_busy[0] & bank_done[0];
    r2      = r1 & bank_busy[1] & bank_done[1];
    n_ret   = pair_count(r1, r2);
    head_d  = head_q + IDX_W'(n_ret);
    tail_d  = tail_q + IDX_W'(n_alloc);
    count_d = count_q + (IDX_W+1)'(n_alloc) - (IDX_W+1)'(n_ret);
    rv1_d   = r1;
    rv2_d   = r2;
    ri1_d   = r1 ? head_q  : '0;
    ri2_d   = r2 ? head_p1 : '0;
  end

  // Pointer, occupancy and retire-pulse registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      rv1_q   <= 1'b0;
      rv2_q   <= 1'b0;
      ri1_q   <= '0;
      ri2_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      rv1_q   <= rv1_d;
      rv2_q   <= rv2_d;
      ri1_q   <= ri1_d;
      ri2_q   <= ri2_d;
    end
  end

  assign retire_valid_1     = rv1_q;
  assign retire_valid_2     = rv2_q;
  assign retire_ROB_index_1 = ri1_q;
  assign retire_ROB_index_2 = ri2_q;
  assign count              = count_q;
  assign empty              = (count_q == '0);

endmodule

// File: tb/tb_rob_retire_tracker.sv
// Self-checking bench for rob_retire_tracker: directed table, hand-written
// corner sequences and a randomized run against a program-order queue model.
module tb_rob_retire_tracker;

  localparam int DEPTH = 64;
  localparam int IDX_W = 6;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             alloc_req_1, alloc_req_2;
  logic             alloc_ready;
  logic [IDX_W-1:0] alloc_ROB_index_1, alloc_ROB_index_2;
  logic             FU_1_valid, FU_2_valid, FU_3_valid, completed_valid;
  logic [IDX_W-1:0] FU_1_ROB_index, FU_2_ROB_index, FU_3_ROB_index, completed_ROB_index;
  logic             retire_valid_1, retire_valid_2;
  logic [IDX_W-1:0] retire_ROB_index_1, retire_ROB_index_2;
  logic [IDX_W:0]   count;
  logic             empty;

  always #5 clk = ~clk;

  rob_retire_tracker #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .alloc_req_1         (alloc_req_1),
    .alloc_req_2         (alloc_req_2),
    .alloc_ready         (alloc_ready),
    .alloc_ROB_index_1   (alloc_ROB_index_1),
    .alloc_ROB_index_2   (alloc_ROB_index_2),
    .FU_1_valid          (FU_1_valid),
    .FU_1_ROB_index      (FU_1_ROB_index),
    .FU_2_valid          (FU_2_valid),
    .FU_2_ROB_index      (FU_2_ROB_index),
    .FU_3_valid          (FU_3_valid),
    .FU_3_ROB_index      (FU_3_ROB_index),
    .completed_valid     (completed_valid),
    .completed_ROB_index (completed_ROB_index),
    .retire_valid_1      (retire_valid_1),
    .retire_valid_2      (retire_valid_2),
    .retire_ROB_index_1  (retire_ROB_index_1),
    .retire_ROB_index_2  (retire_ROB_index_2),
    .count               (count),
    .empty               (empty)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: program-order queue of live indices plus a done flag per index.
  int q[$];
  bit mdone[DEPTH];
  int mtail;
  int exp_rv1, exp_rv2, exp_ri1, exp_ri2;

  typedef struct {
    bit a1; bit a2;
    bit v1; int i1; bit v2; int i2; bit v3; int i3; bit vl; int il;
    int ecount; bit erv1; int eri1; bit erv2; int eri2; int etail;
  } vec_t;
  vec_t tbl[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, expv);
    end
  endtask

  function automatic bit in_q(input int idx);
    foreach (q[k]) if (q[k] == idx) return 1'b1;
    return 1'b0;
  endfunction

  task automatic clear_inputs();
    alloc_req_1 = 0; alloc_req_2 = 0;
    FU_1_valid = 0; FU_2_valid = 0; FU_3_valid = 0; completed_valid = 0;
    FU_1_ROB_index = 0; FU_2_ROB_index = 0; FU_3_ROB_index = 0; completed_ROB_index = 0;
  endtask

  // Advance the model by one edge from the current inputs, clock, then compare.
  task automatic step();
    bit r1, r2, ready;
    if (!rst_n) begin
      q.delete();
      foreach (mdone[k]) mdone[k] = 0;
      mtail = 0;
      r1 = 0; r2 = 0;
      exp_ri1 = 0; exp_ri2 = 0;
    end else begin
      r1 = (q.size() >= 1) && mdone[q[0]];
      r2 = r1 && (q.size() >= 2) && mdone[q[1]];
      exp_ri1 = r1 ? q[0] : 0;
      exp_ri2 = r2 ? q[1] : 0;
      ready = (q.size() <= DEPTH - 2);
      if (FU_1_valid && in_q(int'(FU_1_ROB_index))) mdone[FU_1_ROB_index] = 1;
      if (FU_2_valid && in_q(int'(FU_2_ROB_index))) mdone[FU_2_ROB_index] = 1;
      if (FU_3_valid && in_q(int'(FU_3_ROB_index))) mdone[FU_3_ROB_index] = 1;
      if (completed_valid && in_q(int'(completed_ROB_index))) mdone[completed_ROB_index] = 1;
      if (r1) begin mdone[q[0]] = 0; void'(q.pop_front()); end
      if (r2) begin mdone[q[0]] = 0; void'(q.pop_front()); end
      if (ready && alloc_req_1) begin
        q.push_back(mtail); mdone[mtail] = 0; mtail = (mtail + 1) % DEPTH;
        if (alloc_req_2) begin
          q.push_back(mtail); mdone[mtail] = 0; mtail = (mtail + 1) % DEPTH;
        end
      end
    end
    exp_rv1 = r1; exp_rv2 = r2;
    @(posedge clk); #1;
    chk("count", count, q.size());
    chk("empty", empty, q.size() == 0);
    chk("alloc_ready", alloc_ready, q.size() <= DEPTH - 2);
    chk("alloc_idx1", alloc_ROB_index_1, mtail);
    chk("alloc_idx2", alloc_ROB_index_2, (mtail + 1) % DEPTH);
    chk("retire_valid_1", retire_valid_1, exp_rv1);
    chk("retire_idx_1", retire_ROB_index_1, exp_ri1);
    chk("retire_valid_2", retire_valid_2, exp_rv2);
    chk("retire_idx_2", retire_ROB_index_2, exp_ri2);
  endtask

  task automatic do_reset(input int cycles);
    clear_inputs();
    rst_n = 0;
    for (int c = 0; c < cycles; c++) step();
    rst_n = 1;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_empty"}, empty, 1);
    chk({tag, "_alloc_ready"}, alloc_ready, 1);
    chk({tag, "_alloc_idx1"}, alloc_ROB_index_1, 0);
    chk({tag, "_alloc_idx2"}, alloc_ROB_index_2, 1);
    chk({tag, "_rv1"}, retire_valid_1, 0);
    chk({tag, "_rv2"}, retire_valid_2, 0);
  endtask

  initial begin
    int last;
    bit have_last;
    int guard;
    int pa, pc;

    // a1 a2 | v1 i1 v2 i2 v3 i3 vl il | count rv1 ri1 rv2 ri2 tail
    tbl[0]  = '{1,1, 0,0, 0,0, 0,0, 0,0, 2, 0,0, 0,0, 2};
    tbl[1]  = '{1,1, 0,0, 0,0, 0,0, 0,0, 4, 0,0, 0,0, 4};
    tbl[2]  = '{0,0, 1,0, 1,1, 1,2, 1,3, 4, 0,0, 0,0, 4};
    tbl[3]  = '{0,0, 0,0, 0,0, 0,0, 0,0, 2, 1,0, 1,1, 4};
    tbl[4]  = '{0,0, 0,0, 0,0, 0,0, 0,0, 0, 1,2, 1,3, 4};
    tbl[5]  = '{0,0, 0,0, 0,0, 0,0, 0,0, 0, 0,0, 0,0, 4};
    tbl[6]  = '{1,1, 0,0, 0,0, 0,0, 0,0, 2, 0,0, 0,0, 6};
    tbl[7]  = '{1,0, 0,0, 0,0, 0,0, 0,0, 3, 0,0, 0,0, 7};
    tbl[8]  = '{0,0, 1,6, 0,0, 0,0, 0,0, 3, 0,0, 0,0, 7};
    tbl[9]  = '{0,0, 0,0, 0,0, 0,0, 1,5, 3, 0,0, 0,0, 7};
    tbl[10] = '{0,0, 0,0, 0,0, 1,4, 0,0, 3, 0,0, 0,0, 7};
    tbl[11] = '{0,0, 0,0, 0,0, 0,0, 0,0, 1, 1,4, 1,5, 7};
    tbl[12] = '{0,0, 0,0, 0,0, 0,0, 0,0, 0, 1,6, 0,0, 7};
    tbl[13] = '{0,0, 0,0, 0,0, 0,0, 0,0, 0, 0,0, 0,0, 7};

    clear_inputs();
    rst_n = 0;
    mtail = 0;

    // Reset for two cycles
    do_reset(2);
    check_reset_values("reset");

    // Directed table: pre-advance tail to 4, then out-of-order completion of 4,5,6
    foreach (tbl[i]) begin
      alloc_req_1 = tbl[i].a1; alloc_req_2 = tbl[i].a2;
      FU_1_valid = tbl[i].v1; FU_1_ROB_index = IDX_W'(tbl[i].i1);
      FU_2_valid = tbl[i].v2; FU_2_ROB_index = IDX_W'(tbl[i].i2);
      FU_3_valid = tbl[i].v3; FU_3_ROB_index = IDX_W'(tbl[i].i3);
      completed_valid = tbl[i].vl; completed_ROB_index = IDX_W'(tbl[i].il);
      step();
      chk($sformatf("vec%0d_count", i), count, tbl[i].ecount);
      chk($sformatf("vec%0d_rv1", i), retire_valid_1, tbl[i].erv1);
      chk($sformatf("vec%0d_ri1", i), retire_ROB_index_1, tbl[i].eri1);
      chk($sformatf("vec%0d_rv2", i), retire_valid_2, tbl[i].erv2);
      chk($sformatf("vec%0d_ri2", i), retire_ROB_index_2, tbl[i].eri2);
      chk($sformatf("vec%0d_tail", i), alloc_ROB_index_1, tbl[i].etail);
    end
    clear_inputs();

    // Full: 62 allocated, one more single, then a dropped request
    do_reset(1);
    for (int i = 0; i < 31; i++) begin
      alloc_req_1 = 1; alloc_req_2 = 1; step();
    end
    clear_inputs();
    chk("full_62_count", count, 62);
    chk("full_62_ready", alloc_ready, 1);
    alloc_req_1 = 1; step();
    chk("full_63_count", count, 63);
    chk("full_63_ready", alloc_ready, 0);
    alloc_req_1 = 1; alloc_req_2 = 1; step();
    chk("full_drop_count", count, 63);
    chk("full_drop_tail", alloc_ROB_index_1, 63);
    clear_inputs();
    FU_2_valid = 1; FU_2_ROB_index = 0; step();
    clear_inputs();
    chk("full_cpl_rv1", retire_valid_1, 0);
    chk("full_cpl_ready", alloc_ready, 0);
    step();
    chk("full_ret_rv1", retire_valid_1, 1);
    chk("full_ret_ri1", retire_ROB_index_1, 0);
    chk("full_ret_ready", alloc_ready, 1);
    alloc_req_1 = 1; alloc_req_2 = 1; step();
    clear_inputs();
    chk("full_64_count", count, 64);
    chk("full_64_ready", alloc_ready, 0);
    chk("full_64_tail", alloc_ROB_index_1, 1);

    // Wrap-around: walk head to 63, then retire 63 and 0 together
    do_reset(1);
    for (int i = 0; i < 31; i++) begin
      alloc_req_1 = 1; alloc_req_2 = 1;
      if (i > 0) begin
        FU_1_valid = 1; FU_1_ROB_index = IDX_W'(2*i-2);
        FU_2_valid = 1; FU_2_ROB_index = IDX_W'(2*i-1);
      end
      step();
      clear_inputs();
    end
    alloc_req_1 = 1; FU_1_valid = 1; FU_1_ROB_index = 60; FU_2_valid = 1; FU_2_ROB_index = 61;
    step(); clear_inputs();
    alloc_req_1 = 1; FU_1_valid = 1; FU_1_ROB_index = 62;
    step(); clear_inputs();
    step(); step(); step();
    chk("wrap_pre_count", count, 1);
    chk("wrap_pre_tail", alloc_ROB_index_1, 0);
    alloc_req_1 = 1; step(); clear_inputs();
    FU_1_valid = 1; FU_1_ROB_index = 63; FU_3_valid = 1; FU_3_ROB_index = 0;
    step(); clear_inputs();
    step();
    chk("wrap_rv1", retire_valid_1, 1);
    chk("wrap_ri1", retire_ROB_index_1, 63);
    chk("wrap_rv2", retire_valid_2, 1);
    chk("wrap_ri2", retire_ROB_index_2, 0);
    chk("wrap_count", count, 0);
    chk("wrap_tail", alloc_ROB_index_1, 1);

    // Simultaneous dual-allocate, triple completion and dual retire
    alloc_req_1 = 1; alloc_req_2 = 1; step();
    alloc_req_1 = 1; alloc_req_2 = 1; step();
    alloc_req_1 = 1; alloc_req_2 = 1;
    FU_1_valid = 1; FU_1_ROB_index = 1; FU_2_valid = 1; FU_2_ROB_index = 2;
    step(); clear_inputs();
    chk("sim_pre_count", count, 6);
    alloc_req_1 = 1; alloc_req_2 = 1;
    FU_1_valid = 1; FU_1_ROB_index = 3; FU_2_valid = 1; FU_2_ROB_index = 4;
    FU_3_valid = 1; FU_3_ROB_index = 5; completed_valid = 1; completed_ROB_index = 40;
    step(); clear_inputs();
    chk("sim_count", count, 6);
    chk("sim_ri1", retire_ROB_index_1, 1);
    chk("sim_ri2", retire_ROB_index_2, 2);
    step();
    chk("sim_next_ri1", retire_ROB_index_1, 3);
    chk("sim_next_ri2", retire_ROB_index_2, 4);
    step();
    chk("sim_last_rv2", retire_valid_2, 0);
    chk("sim_last_count", count, 3);
    FU_1_valid = 1; FU_1_ROB_index = 6; FU_2_valid = 1; FU_2_ROB_index = 7;
    FU_3_valid = 1; FU_3_ROB_index = 8;
    step(); clear_inputs();
    step(); step();
    chk("sim_drain_count", count, 0);

    // Stale completion to non-busy 40 must not mark a later allocation of 40
    have_last = 0; last = 0; guard = 0;
    while (mtail != 40 && guard < 2*DEPTH) begin
      alloc_req_1 = 1;
      if (have_last) begin FU_1_valid = 1; FU_1_ROB_index = IDX_W'(last); end
      last = mtail; have_last = 1;
      step(); clear_inputs();
      guard++;
    end
    chk("stale_reach_tail", alloc_ROB_index_1, 40);
    FU_1_valid = 1; FU_1_ROB_index = IDX_W'(last);
    completed_valid = 1; completed_ROB_index = 40;
    step(); clear_inputs();
    step(); step();
    chk("stale_empty", empty, 1);
    alloc_req_1 = 1; step(); clear_inputs();
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("stale_hold%0d_rv1", i), retire_valid_1, 0);
      chk($sformatf("stale_hold%0d_count", i), count, 1);
    end
    FU_2_valid = 1; FU_2_ROB_index = 40; step(); clear_inputs();
    step();
    chk("stale_ret_rv1", retire_valid_1, 1);
    chk("stale_ret_ri1", retire_ROB_index_1, 40);

    // Reset mid-operation: 10 busy, 3 done, none at head
    for (int i = 0; i < 5; i++) begin
      alloc_req_1 = 1; alloc_req_2 = 1; step();
    end
    clear_inputs();
    FU_1_valid = 1; FU_1_ROB_index = 42; FU_2_valid = 1; FU_2_ROB_index = 43;
    FU_3_valid = 1; FU_3_ROB_index = 44;
    step(); clear_inputs();
    chk("mid_count", count, 10);
    do_reset(1);
    check_reset_values("midrst");
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("midrst_quiet%0d_rv1", i), retire_valid_1, 0);
      chk($sformatf("midrst_quiet%0d_count", i), count, 0);
    end

    // Randomized traffic with alternating fill/drain phases
    do_reset(1);
    for (int cyc = 0; cyc < 4000; cyc++) begin
      pa = ((cyc / 400) % 2 == 0) ? 85 : 30;
      pc = ((cyc / 400) % 2 == 0) ? 20 : 60;
      rst_n = ($urandom_range(0, 799) != 0);
      alloc_req_1 = ($urandom_range(0, 99) < pa);
      alloc_req_2 = ($urandom_range(0, 99) < 50);
      FU_1_valid = ($urandom_range(0, 99) < pc);
      FU_2_valid = ($urandom_range(0, 99) < pc);
      FU_3_valid = ($urandom_range(0, 99) < pc);
      completed_valid = ($urandom_range(0, 99) < pc);
      FU_1_ROB_index = (q.size() > 0 && $urandom_range(0, 3) != 0) ?
                       IDX_W'(q[$urandom_range(0, q.size()-1)]) : IDX_W'($urandom_range(0, DEPTH-1));
      FU_2_ROB_index = (q.size() > 0 && $urandom_range(0, 3) != 0) ?
                       IDX_W'(q[$urandom_range(0, q.size()-1)]) : IDX_W'($urandom_range(0, DEPTH-1));
      FU_3_ROB_index = (q.size() > 0 && $urandom_range(0, 3) != 0) ?
                       IDX_W'(q[$urandom_range(0, q.size()-1)]) : IDX_W'($urandom_range(0, DEPTH-1));
      completed_ROB_index = (q.size() > 0 && $urandom_range(0, 3) != 0) ?
                       IDX_W'(q[$urandom_range(0, q.size()-1)]) : IDX_W'($urandom_range(0, DEPTH-1));
      step();
    end
    rst_n = 1;
    clear_inputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
